// File: rtl/fifo_uart_tx_if.sv
`timescale 1ns/1ps
// Read-side bundle between fifo_buffer and its serial drain stage.
// master pops words, slave supplies data and the empty flag.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;

  modport master (
    output rd_en,
    input  rd_data,
    input  empty
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output empty
  );
endinterface

// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
// Serial drain for fifo_buffer: start bit, LSB-first data, stop bit.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit before stop.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  fifo_uart_tx_if.master rd,
  output logic           tx,
  output logic           busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state;
  logic [BW-1:0]         baud;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  bit_end;
  logic                  last_bit;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity;
`endif

  assign shift_nxt = shift_reg >> 1;
  assign bit_end   = (baud == BAUD_MAX);
  assign last_bit  = (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      rd.rd_en  <= 1'b0;
      busy      <= 1'b0;
      baud      <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      rd.rd_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable && !rd.empty) begin
            state    <= FETCH;
            rd.rd_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        // rd_data is valid one edge after the pop strobe
        WAIT: begin
          state     <= START;
          shift_reg <= rd.rd_data;
          tx        <= 1'b0;
          baud      <= '0;
          bit_cnt   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
          parity    <= ^rd.rd_data;
`endif
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            baud  <= '0;
            tx    <= shift_reg[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud      <= '0;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt + 1'b1;
            if (last_bit) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx <= shift_nxt[0];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            baud  <= '0;
            tx    <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            baud  <= '0;
            busy  <= 1'b0;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
// Bench for fifo_uart_tx with a queue-based buffer model and a line decoder.
// Build with FIFO_UART_TX_PARITY_EN to check the parity variant.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 2 + DW + P;
  localparam int NV = 7;

  typedef struct {
    logic [DW-1:0] data;
    logic [0:DW-1] seq;
    logic          par;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic tx;
  logic busy;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .rd    (bus.master),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int underflow = 0;
  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_word = '0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  vec_t          tv[NV];

  initial begin
    bus.empty   = 1'b1;
    bus.rd_data = '0;
    forever begin
      @(posedge clk);
      if (bus.rd_en === 1'b1) begin
        pops++;
        if (fq.size() == 0) underflow++;
        else bus.rd_data <= fq.pop_front();
      end
      if (wr_req) fq.push_back(wr_word);
      bus.empty <= (fq.size() == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    wr_word = w;
    wr_req  = 1'b1;
    @(posedge clk);
    #1 wr_req = 1'b0;
  endtask

  function automatic logic [0:DW-1] lsb_seq(input logic [DW-1:0] d);
    logic [0:DW-1] s;
    for (int i = 0; i < DW; i++) s[i] = ((d >> i) & 1) != 0;
    return s;
  endfunction

  function automatic logic even_par(input logic [DW-1:0] d);
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += int'((d >> i) & 1);
    return (ones % 2) == 1;
  endfunction

  task automatic wait_fetch(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.rd_en !== 1'b1 && waited < budget);
    checks++;
    if (bus.rd_en !== 1'b1) begin
      errors++;
      $display("FAIL fetch: no rd_en within %0d cycles", budget);
    end
  endtask

  task automatic check_frame(input string tag, input logic [0:DW-1] seq,
                             input logic par);
    logic [0:NB-1] fb;
    logic          tx_ok;
    logic          busy_ok;
    @(negedge clk);
    chk({tag, " wait rd_en"}, 32'(bus.rd_en), 0);
    chk({tag, " wait tx"}, 32'(tx), 1);
    fb[0] = 1'b0;
    for (int i = 0; i < DW; i++) fb[1+i] = seq[i];
    if (P == 1) fb[NB-2] = par;
    fb[NB-1] = 1'b1;
    for (int b = 0; b < NB; b++) begin
      tx_ok   = 1'b1;
      busy_ok = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (tx !== fb[b]) tx_ok = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
      chk($sformatf("%s bit%0d {busy,tx}", tag, b),
          32'({busy_ok, tx_ok ? fb[b] : ~fb[b]}), 32'({1'b1, fb[b]}));
    end
    @(negedge clk);
    chk({tag, " end busy"}, 32'(busy), 0);
    chk({tag, " end tx"}, 32'(tx), 1);
  endtask

  initial begin
    int            w;
    int            snap;
    logic [DW-1:0] d;

    tv[0] = '{8'hA5, 8'b10100101, 1'b0};
    tv[1] = '{8'h07, 8'b11100000, 1'b1};
    tv[2] = '{8'h03, 8'b11000000, 1'b0};
    tv[3] = '{8'h00, 8'b00000000, 1'b0};
    tv[4] = '{8'hFF, 8'b11111111, 1'b0};
    tv[5] = '{8'h80, 8'b00000001, 1'b1};
    tv[6] = '{8'h3C, 8'b00111100, 1'b0};

    enable = 1'b1;
    push(tv[0].data);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset tx", 32'(tx), 1);
      chk("reset rd_en", 32'(bus.rd_en), 0);
      chk("reset busy", 32'(busy), 0);
    end
    chk("reset no pop", pops, 0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (i > 0) push(tv[i].data);
      wait_fetch(50, w);
      check_frame($sformatf("vec%0d", i), tv[i].seq, tv[i].par);
    end
    chk("pops after table", pops, NV);

    repeat (100) @(negedge clk);
    chk("empty gating pops", pops, NV);
    chk("empty gating busy", 32'(busy), 0);

    snap = pops;
    fork
      begin
        for (int i = 0; i < 8; i++) push(DW'(i));
      end
      begin
        for (int i = 0; i < 8; i++) begin
          wait_fetch(50, w);
          if (i > 0) chk($sformatf("burst gap%0d", i), w, 1);
          d = DW'(i);
          check_frame($sformatf("burst%0d", i), lsb_seq(d), even_par(d));
        end
      end
    join
    repeat (30) @(negedge clk);
    chk("burst empty", 32'(bus.empty), 1);
    chk("burst pops", pops, snap + 8);

    push(8'h5A);
    push(8'hC3);
    wait_fetch(50, w);
    fork
      check_frame("en_drop", lsb_seq(8'h5A), even_par(8'h5A));
      begin
        repeat (14) @(negedge clk);
        enable = 1'b0;
      end
    join
    snap = pops;
    repeat (60) @(negedge clk);
    chk("en_drop no pop", pops, snap);
    chk("en_drop pending", 32'(bus.empty), 0);
    enable = 1'b1;
    wait_fetch(50, w);
    check_frame("en_resume", lsb_seq(8'hC3), even_par(8'hC3));

    push(8'h96);
    push(8'h69);
    wait_fetch(50, w);
    repeat (18) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst tx", 32'(tx), 1);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst rd_en", 32'(bus.rd_en), 0);
    @(negedge clk);
    reset = 1'b1;
    wait_fetch(50, w);
    check_frame("midrst next", lsb_seq(8'h69), even_par(8'h69));

    fork
      begin
        for (int i = 0; i < 16; i++) begin
          repeat ($urandom_range(0, 60)) @(posedge clk);
          #1;
          d = DW'($urandom);
          exp_q.push_back(d);
          push(d);
        end
      end
      begin
        logic [DW-1:0] e;
        for (int i = 0; i < 16; i++) begin
          wait_fetch(3000, w);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rand%0d: frame with no queued word", i);
            e = '0;
          end else begin
            e = exp_q.pop_front();
          end
          check_frame($sformatf("rand%0d", i), lsb_seq(e), even_par(e));
        end
      end
    join

    repeat (20) @(negedge clk);
    chk("no underflow", underflow, 0);
    chk("final empty", 32'(bus.empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial drain stage placed directly downstream of `fifo_buffer`. Pops one word at a time through the buffer's `rd_en`/`rd_data`/`empty` interface and transmits it LSB-first on a single asynchronous serial line: start bit, DATA_WIDTH data bits, optional parity bit, one stop bit. Each bit is held for a fixed number of clock cycles. The buffer absorbs bursts from its writer, and this block converts them into a paced bit stream.

## Interface
- `DATA_WIDTH`, 8, word width; must equal the `fifo_buffer` DATA_WIDTH.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; must be ≥ 2.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when high, the block may start new frames.
- `empty`  in  1  `fifo_buffer` empty flag.
- `rd_data`  in  DATA_WIDTH  `fifo_buffer` read data. Valid after the edge that samples `rd_en` high.
- `rd_en`  out  1  pop strobe to `fifo_buffer`. Registered; high for exactly one cycle per word.
- `tx`  out  1  serial line; idle level is high.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE → FETCH when `enable && !empty` is sampled.
  - FETCH → WAIT unconditionally.
  - WAIT → START unconditionally.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY (or STOP when parity is compiled out) after DATA_WIDTH bits.
  - PARITY → STOP after CLKS_PER_BIT cycles.
  - STOP → IDLE after CLKS_PER_BIT cycles.
- FETCH: `rd_en` = 1 for this one cycle only.
- WAIT: `rd_en` = 0. At the exiting edge, `rd_data` is loaded into the shift register and `tx` is driven 0.
- DATA: `tx` = shift_reg[0]. The register shifts right at each bit boundary. A bit index counter of width clog2(DATA_WIDTH+1) counts DATA_WIDTH bits.
- Baud counter: width clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is cleared on entering START.
- Reset values: `tx` = 1, `rd_en` = 0, `busy` = 0, state = IDLE, all counters = 0, shift register = 0.
- `empty` is sampled only in IDLE. The block never asserts `rd_en` while `empty` is high, so it never underflows the buffer.
- `enable` is sampled only in IDLE. Deasserting it mid-frame lets the current frame finish; no new fetch follows.
- The buffer may be written during any state. Simultaneous write and pop at the buffer is the buffer's concern; this block needs only the one-cycle `rd_en` pulse.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronously). `tx` goes high, and the in-flight word is discarded without retransmission.

## Timing
- Latency: `enable && !empty` is sampled at edge k.
  - `rd_en` is high in cycle k..k+1.
  - Data is captured and the start bit begins at edge k+2.
- Frame length from the start-bit edge is (2 + DATA_WIDTH + P) × CLKS_PER_BIT cycles, where P = 1 with parity, 0 without.
- Back-to-back frames: the stop bit ends at edge s and the next start bit begins at edge s+3. The minimum gap is 3 cycles at tx = 1 (IDLE, FETCH, WAIT).
- `busy` rises at the edge entering FETCH and falls at the edge entering IDLE.

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - `tx` carries the even-parity bit (XOR of all data bits) for CLKS_PER_BIT cycles between the last data bit and the stop bit.
- `FIFO_UART_TX_PARITY_EN` undefined:
  - PARITY state and parity logic are absent.
  - DATA goes straight to STOP, and P = 0.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `empty`=0 and `enable`=1 → `tx`=1, `rd_en`=0, `busy`=0 throughout; no pop occurs.
- Single word, DATA_WIDTH=8, CLKS_PER_BIT=4, no parity: buffer holds 8'hA5 → exactly one `rd_en` pulse, then `tx` = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total), then `busy`=0.
- Burst: words 0..7 written to a DEPTH_BITS=3 buffer until `full` → 8 frames in order, each separated by exactly 3 idle-high cycles; `empty`=1 afterwards and no ninth `rd_en`.
- Empty/enable gating:
  - `empty`=1 with `enable`=1 for 100 cycles → no `rd_en` pulse.
  - `enable` dropped during the data bits of a frame → that frame completes, and no further `rd_en` pulse occurs while `enable`=0.
- Reset mid-frame: assert reset during data bit 3 → `tx`=1 and `busy`=0 immediately. After release, the next buffered word is transmitted from a fresh start bit.
- Parity build: with `FIFO_UART_TX_PARITY_EN` defined, send 8'h07 → parity bit = 1 and the frame is 44 cycles long. Then send 8'h03 → parity bit = 0.
